// File: rtl/sequence_player_if.sv
// rtl/sequence_player_if.sv - game-side bundle between the game FSM and the sequence player
//   master: game FSM / LED logic side (drives start, abort, segment; observes playback)
//   slave : sequence_player (consumes requests, drives playback outputs)
interface sequence_player_if #(
  parameter int DEPTH = 32
) ();
  logic                         start;
  logic                         abort;
  logic [DEPTH-1:0][2:0]        segment;
  logic                         led_on;
  logic [1:0]                   colour_out;
  logic [$clog2(DEPTH)-1:0]     position;
  logic [$clog2(DEPTH+1)-1:0]   length;
  logic                         busy;
  logic                         done;

  modport master (
    output start, abort, segment,
    input  led_on, colour_out, position, length, busy, done
  );

  modport slave (
    input  start, abort, segment,
    output led_on, colour_out, position, length, busy, done
  );
endinterface

// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - plays the assigned colour history back to the LEDs, oldest first
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : sequence_player_if.slave
//           start/abort/segment in; led_on, colour_out, position, length, busy, done out
module sequence_player #(
  parameter int DEPTH      = 32,
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000
) (
  input  logic              clk,
  input  logic              reset,
  sequence_player_if.slave  bus
);

  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = $clog2(DEPTH + 1);
  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SCAN, SHOW, GAP, DONE} state_e;

  state_e                 state_q;
  logic [DEPTH-1:0][2:0]  snap_q;
  logic [PW-1:0]          idx_q;
  logic [CW-1:0]          cnt_q;
  logic                   led_on_q;
  logic [1:0]             colour_q;
  logic [PW-1:0]          position_q;
  logic [LW-1:0]          length_q;
  logic                   busy_q;
  logic                   done_q;

  logic [LW-1:0]          scan_len_d;
  logic [PW-1:0]          last_idx_d;
  logic                   hole;

  // Count assigned slots from the newest end; anything past the first hole is ignored.
  always_comb begin
    scan_len_d = '0;
    hole       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (snap_q[i][2]) hole = 1'b1;
      if (!hole) scan_len_d = scan_len_d + LW'(1);
    end
  end

  // Oldest assigned slot; computed at full length width so length=DEPTH lands on DEPTH-1.
  assign last_idx_d = PW'(scan_len_d - LW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      led_on_q   <= 1'b0;
      colour_q   <= 2'b00;
      position_q <= '0;
      length_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.abort && state_q != IDLE) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      led_on_q <= 1'b0;
      colour_q <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            snap_q  <= bus.segment;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          length_q <= scan_len_d;
          if (scan_len_d == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q      <= last_idx_d;
            position_q <= '0;
            cnt_q      <= '0;
            led_on_q   <= 1'b1;
            colour_q   <= snap_q[last_idx_d][1:0];
            state_q    <= SHOW;
          end
        end
        SHOW: begin
          if (cnt_q == ON_LAST) begin
            cnt_q    <= '0;
            led_on_q <= 1'b0;
            colour_q <= 2'b00;
            state_q  <= GAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == OFF_LAST) begin
            cnt_q <= '0;
            if (idx_q == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q      <= idx_q - PW'(1);
              position_q <= position_q + PW'(1);
              led_on_q   <= 1'b1;
              colour_q   <= snap_q[idx_q - PW'(1)][1:0];
              state_q    <= SHOW;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.led_on     = led_on_q;
  assign bus.colour_out = colour_q;
  assign bus.position   = position_q;
  assign bus.length     = length_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// tb/tb_sequence_player.sv - randomized and directed bench for sequence_player
module tb_sequence_player;

  localparam int DEPTH = 32;
  localparam int ON    = 3;
  localparam int OFF   = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  // Expected output word: {busy, done, led_on, colour[1:0], position[4:0], length[5:0]}
  logic [15:0] trace[$];
  int          m_len = 0;
  int          m_pos = 0;

  sequence_player_if #(.DEPTH(DEPTH)) bus ();

  sequence_player #(
    .DEPTH(DEPTH), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sample();
    return {bus.busy, bus.done, bus.led_on, bus.colour_out, bus.position, bus.length};
  endfunction

  function automatic logic [15:0] pk(bit b, bit d, bit l, logic [1:0] c, int p, int n);
    return {b, d, l, c, 5'(p), 6'(n)};
  endfunction

  // Expected cycle-by-cycle outputs, starting with the cycle right after start is taken.
  task automatic build_trace(input logic [DEPTH-1:0][2:0] seg);
    int L = 0;
    logic [1:0] c;
    while (L < DEPTH && seg[L][2] == 1'b0) L++;
    trace.delete();
    trace.push_back(pk(1, 0, 0, 2'b00, m_pos, m_len));
    for (int k = 0; k < L; k++) begin
      c = seg[L - 1 - k][1:0];
      for (int t = 0; t < ON; t++)  trace.push_back(pk(1, 0, 1, c, k, L));
      for (int t = 0; t < OFF; t++) trace.push_back(pk(1, 0, 0, 2'b00, k, L));
    end
    m_len = L;
    if (L > 0) m_pos = L - 1;
    trace.push_back(pk(0, 1, 0, 2'b00, m_pos, m_len));
    trace.push_back(pk(0, 0, 0, 2'b00, m_pos, m_len));
  endtask

  task automatic play(input string tag, input logic [DEPTH-1:0][2:0] seg,
                      input int abort_at, input int reset_at);
    int n;
    build_trace(seg);
    n = trace.size();
    bus.segment = seg;
    bus.start   = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(sample()), 32'(trace[i]));
      if (i == abort_at) begin
        bus.start = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        m_pos = int'(trace[i][10:6]);
        m_len = int'(trace[i][5:0]);
        check({tag, "_abort"}, 32'(sample()), 32'({5'b0, trace[i][10:0]}));
        step();
        check({tag, "_abort_idle"}, 32'(sample()), 32'({5'b0, trace[i][10:0]}));
        return;
      end
      if (i == reset_at) begin
        bus.start = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_pos = 0;
        m_len = 0;
        check({tag, "_reset"}, 32'(sample()), 32'h0);
        return;
      end
      // Live inputs are scrambled while playing: the snapshot and the busy FSM must ignore them.
      bus.segment = {$urandom, $urandom, $urandom};
      bus.start   = (i < n - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      step();
    end
    bus.start = 1'b0;
  endtask

  logic [DEPTH-1:0][2:0] seg;
  int L;
  int ab;

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.segment = '0;
    step();
    step();
    reset = 1'b0;
    check("reset", 32'(sample()), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle", 32'(sample()), 32'h0);
    end

    for (int i = 0; i < DEPTH; i++) seg[i] = 3'b100;
    seg[0] = 3'b010;
    seg[1] = 3'b001;
    play("len2", seg, -1, -1);
    check("len2_length", 32'(bus.length), 32'd2);

    for (int i = 0; i < DEPTH; i++) seg[i] = 3'b100;
    play("len0", seg, -1, -1);

    for (int i = 0; i < DEPTH; i++) seg[i] = 3'(i % 4);
    play("full", seg, -1, -1);
    check("full_length", 32'(bus.length), 32'd32);

    for (int i = 0; i < DEPTH; i++) seg[i] = 3'b100;
    seg[0] = 3'b011;
    seg[1] = 3'b100;
    seg[2] = 3'b000;
    play("hole", seg, -1, -1);

    // Second colour of a two-colour run: SHOW at trace index 7, GAP at index 9.
    for (int i = 0; i < DEPTH; i++) seg[i] = 3'b100;
    seg[0] = 3'b010;
    seg[1] = 3'b001;
    play("abort_show", seg, 7, -1);
    play("reset_gap", seg, -1, 9);
    check("post_reset", 32'(sample()), 32'h0);

    bus.abort = 1'b1;
    bus.start = 1'b1;
    for (int i = 0; i < DEPTH; i++) seg[i] = 3'b100;
    seg[0] = 3'b001;
    bus.segment = seg;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("start_wins", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 1 + ON + OFF + 2; i++) step();
    m_len = 1;
    m_pos = 0;
    check("start_wins_end", 32'(sample()), 32'(pk(0, 0, 0, 2'b00, 0, 1)));

    for (int r = 0; r < 25; r++) begin
      L = $urandom_range(0, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        seg[i] = 3'($urandom);
        if (i < L) seg[i][2] = 1'b0;
        else if (i == L) seg[i][2] = 1'b1;
      end
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, 1 + L * (ON + OFF));
      play("rand", seg, ab, -1);
      for (int i = 0; i < $urandom_range(0, 3); i++) begin
        step();
        check("rand_idle", 32'(sample()), 32'(pk(0, 0, 0, 2'b00, m_pos, m_len)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
